// File: rtl/exception_ctrl.sv
// Exception/interrupt controller beside the MEM stage: synchronises interrupts,
// resolves MEM exception flags against WB-bypassed CP0 state, and drives flush/redirect.
module exception_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_ext_i,
    input  logic        timer_int_i,
    output logic [5:0]  int_o,
    input  logic [31:0] excepttype_raw_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic        stall_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] cp0_epc_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state, state_next;
    logic [5:0]  s1, s2;
    logic [31:0] status_eff, cause_eff, epc_eff;
    logic        int_pending;
    logic [31:0] code;
    logic        take;

    always_comb begin
        status_eff = cp0_status_i;
        epc_eff    = cp0_epc_i;
        cause_eff  = cp0_cause_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12)
            status_eff = wb_cp0_data_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14)
            epc_eff = wb_cp0_data_i;
        // Only the software-writable cause fields are forwarded from WB.
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13) begin
            cause_eff[9:8]   = wb_cp0_data_i[9:8];
            cause_eff[23:22] = wb_cp0_data_i[23:22];
        end
    end

    assign cp0_epc_o = epc_eff;

    assign int_pending = ((cause_eff[15:8] & status_eff[15:8]) != 8'h00) &&
                         status_eff[0] && !status_eff[1] &&
                         (current_inst_addr_i != '0);

    always_comb begin
        code = '0;
        if (int_pending)               code = 32'h0000_0001;
        else if (excepttype_raw_i[8])  code = 32'h0000_0008;
        else if (excepttype_raw_i[9])  code = 32'h0000_000A;
        else if (excepttype_raw_i[10]) code = 32'h0000_000D;
        else if (excepttype_raw_i[11]) code = 32'h0000_000C;
        else if (excepttype_raw_i[12]) code = 32'h0000_000E;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= '0;
            s2    <= '0;
            int_o <= '0;
        end else begin
            s1    <= int_ext_i;
            s2    <= s1;
            int_o <= {s2[5] | timer_int_i, s2[4:0]};
        end
    end

    always_comb begin
        state_next   = state;
        excepttype_o = '0;
        flush_o      = 1'b0;
        take         = 1'b0;
        case (state)
            IDLE: begin
                if (!stall_i) begin
                    excepttype_o = code;
                    if (code != '0) begin
                        take       = 1'b1;
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                flush_o    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // CP0 must never see an exception while reset is asserted.
        if (!rst)
            excepttype_o = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            new_pc_o <= '0;
        end else begin
            state <= state_next;
            if (take)
                new_pc_o <= (code == 32'h0000_000E) ? epc_eff : HANDLER_ADDR;
        end
    end

    assign current_inst_addr_o = current_inst_addr_i;
    assign is_in_delayslot_o   = is_in_delayslot_i;

    logic unused_bits;
    assign unused_bits = &{1'b0, excepttype_raw_i[31:13], excepttype_raw_i[7:0],
                           status_eff[31:16], status_eff[7:2],
                           cause_eff[31:16], cause_eff[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: vector table for code resolution and bypass,
// hand sequences for synchroniser latency, stall, flush and reset behaviour.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_ext_i;
    logic        timer_int_i;
    logic [5:0]  int_o;
    logic [31:0] excepttype_raw_i;
    logic [31:0] current_inst_addr_i;
    logic        is_in_delayslot_i;
    logic        stall_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic [31:0] cp0_epc_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    int tests = 0;
    int fails = 0;

    exception_ctrl #(.HANDLER_ADDR(32'h0000_0020)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .int_ext_i           (int_ext_i),
        .timer_int_i         (timer_int_i),
        .int_o               (int_o),
        .excepttype_raw_i    (excepttype_raw_i),
        .current_inst_addr_i (current_inst_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .stall_i             (stall_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .wb_cp0_we_i         (wb_cp0_we_i),
        .wb_cp0_waddr_i      (wb_cp0_waddr_i),
        .wb_cp0_data_i       (wb_cp0_data_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .cp0_epc_o           (cp0_epc_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] raw;
        logic [31:0] addr;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exp_type;
        logic [31:0] exp_epc;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] raw, logic [31:0] addr, logic [31:0] status,
                                logic [31:0] cause, logic [31:0] epc, logic we,
                                logic [4:0] waddr, logic [31:0] wdata,
                                logic [31:0] exp_type, logic [31:0] exp_epc,
                                logic [31:0] exp_pc);
        vec_t v;
        v.raw = raw; v.addr = addr; v.status = status; v.cause = cause; v.epc = epc;
        v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.exp_type = exp_type; v.exp_epc = exp_epc; v.exp_pc = exp_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        excepttype_raw_i    = '0;
        current_inst_addr_i = '0;
        is_in_delayslot_i   = 1'b0;
        stall_i             = 1'b0;
        cp0_status_i        = '0;
        cp0_cause_i         = '0;
        cp0_epc_i           = '0;
        wb_cp0_we_i         = 1'b0;
        wb_cp0_waddr_i      = '0;
        wb_cp0_data_i       = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //            raw          addr    status       cause        epc     we  wa  wdata        type  epc_o  pc
        vecs.push_back(mk(32'h100,  32'h100, 32'h0,     32'h0,       32'h0,   0, 0,  32'h0,      32'h8, 32'h0,   32'h20));
        vecs.push_back(mk(32'h1000, 32'h104, 32'h0,     32'h0,       32'h180, 1, 14, 32'h200,    32'hE, 32'h200, 32'h200));
        vecs.push_back(mk(32'h1000, 32'h108, 32'h0,     32'h0,       32'h180, 1, 12, 32'h0,      32'hE, 32'h180, 32'h180));
        vecs.push_back(mk(32'h1000, 32'h10C, 32'h0,     32'h0,       32'h180, 0, 14, 32'h200,    32'hE, 32'h180, 32'h180));
        vecs.push_back(mk(32'h0,    32'h40,  32'h401,   32'h400,     32'h0,   0, 0,  32'h0,      32'h1, 32'h0,   32'h20));
        vecs.push_back(mk(32'h0,    32'h40,  32'h403,   32'h400,     32'h0,   0, 0,  32'h0,      32'h0, 32'h0,   32'h0));
        vecs.push_back(mk(32'h0,    32'h0,   32'h401,   32'h400,     32'h0,   0, 0,  32'h0,      32'h0, 32'h0,   32'h0));
        vecs.push_back(mk(32'h0,    32'h40,  32'h400,   32'h400,     32'h0,   0, 0,  32'h0,      32'h0, 32'h0,   32'h0));
        vecs.push_back(mk(32'h900,  32'h44,  32'h401,   32'h400,     32'h0,   0, 0,  32'h0,      32'h1, 32'h0,   32'h20));
        vecs.push_back(mk(32'h900,  32'h44,  32'h401,   32'h0,       32'h0,   0, 0,  32'h0,      32'h8, 32'h0,   32'h20));
        vecs.push_back(mk(32'h1800, 32'h48,  32'h0,     32'h0,       32'h0,   0, 0,  32'h0,      32'hC, 32'h0,   32'h20));
        vecs.push_back(mk(32'h200,  32'h4C,  32'h0,     32'h0,       32'h0,   0, 0,  32'h0,      32'hA, 32'h0,   32'h20));
        vecs.push_back(mk(32'h1C00, 32'h50,  32'h0,     32'h0,       32'h0,   0, 0,  32'h0,      32'hD, 32'h0,   32'h20));
        vecs.push_back(mk(32'h0,    32'h54,  32'h301,   32'h0,       32'h0,   1, 13, 32'h100,    32'h1, 32'h0,   32'h20));
        vecs.push_back(mk(32'h0,    32'h58,  32'h401,   32'h0,       32'h0,   1, 13, 32'h400,    32'h0, 32'h0,   32'h0));
        vecs.push_back(mk(32'h0,    32'h5C,  32'h0,     32'h400,     32'h0,   1, 12, 32'h401,    32'h1, 32'h0,   32'h20));
        vecs.push_back(mk(32'hFFFF_E0FF, 32'h60, 32'h0, 32'h0,       32'h0,   0, 0,  32'h0,      32'h0, 32'h0,   32'h0));

        int_ext_i   = '0;
        timer_int_i = 1'b0;
        clear_inputs();
        excepttype_raw_i    = 32'h100;
        current_inst_addr_i = 32'h100;
        rst = 1'b0;
        #12;
        chk("reset_excepttype", excepttype_o, 32'h0);
        chk("reset_flush", {31'b0, flush_o}, 32'h0);
        chk("reset_int_o", {26'b0, int_o}, 32'h0);
        chk("reset_new_pc", new_pc_o, 32'h0);
        clear_inputs();
        #1 rst = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            excepttype_raw_i    = vecs[i].raw;
            current_inst_addr_i = vecs[i].addr;
            is_in_delayslot_i   = i[0];
            cp0_status_i        = vecs[i].status;
            cp0_cause_i         = vecs[i].cause;
            cp0_epc_i           = vecs[i].epc;
            wb_cp0_we_i         = vecs[i].we;
            wb_cp0_waddr_i      = vecs[i].waddr;
            wb_cp0_data_i       = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_type", i), excepttype_o, vecs[i].exp_type);
            chk($sformatf("v%0d_epc", i), cp0_epc_o, vecs[i].exp_epc);
            chk($sformatf("v%0d_addr", i), current_inst_addr_o, vecs[i].addr);
            chk($sformatf("v%0d_ds", i), {31'b0, is_in_delayslot_o}, {31'b0, i[0]});
            tick();
            chk($sformatf("v%0d_flush", i), {31'b0, flush_o},
                {31'b0, vecs[i].exp_type != 32'h0});
            if (vecs[i].exp_type != 32'h0)
                chk($sformatf("v%0d_newpc", i), new_pc_o, vecs[i].exp_pc);
            clear_inputs();
            tick();
            chk($sformatf("v%0d_flush_end", i), {31'b0, flush_o}, 32'h0);
        end

        // Synchroniser: three edges for external lines, one for the timer
        int_ext_i = 6'b000001;
        tick();
        tick();
        chk("sync_edge2", {26'b0, int_o}, 32'h0);
        tick();
        chk("sync_edge3", {26'b0, int_o}, 32'h01);
        int_ext_i   = '0;
        timer_int_i = 1'b1;
        tick();
        chk("timer_edge1", {26'b0, int_o[5]}, 32'h1);
        timer_int_i = 1'b0;
        tick();
        tick();
        tick();
        chk("sync_clear", {26'b0, int_o}, 32'h0);

        // Stall: preload new_pc with a distinct value via ERET
        excepttype_raw_i = 32'h1000; current_inst_addr_i = 32'h200; cp0_epc_i = 32'h300;
        tick();
        chk("stall_pre_pc", new_pc_o, 32'h300);
        clear_inputs();
        tick();
        excepttype_raw_i = 32'h800; current_inst_addr_i = 32'h204; stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_type", c), excepttype_o, 32'h0);
            tick();
            chk($sformatf("stall%0d_flush", c), {31'b0, flush_o}, 32'h0);
            chk($sformatf("stall%0d_pc", c), new_pc_o, 32'h300);
        end
        stall_i = 1'b0;
        #1;
        chk("stall_rel_type", excepttype_o, 32'hC);
        tick();
        chk("stall_rel_flush", {31'b0, flush_o}, 32'h1);
        chk("stall_rel_pc", new_pc_o, 32'h20);
        clear_inputs();
        tick();

        // Code presented only during FLUSH is dropped
        excepttype_raw_i = 32'h1000; current_inst_addr_i = 32'h300; cp0_epc_i = 32'h400;
        tick();
        excepttype_raw_i = 32'h200;
        #1;
        chk("inflush_type", excepttype_o, 32'h0);
        chk("inflush_flush", {31'b0, flush_o}, 32'h1);
        #1 clear_inputs();
        tick();
        chk("dropped_flush", {31'b0, flush_o}, 32'h0);
        chk("dropped_pc", new_pc_o, 32'h400);

        // Back-to-back: held trap is taken again right after FLUSH
        excepttype_raw_i = 32'h400; current_inst_addr_i = 32'h304;
        #1;
        chk("b2b_type1", excepttype_o, 32'hD);
        tick();
        chk("b2b_flush1", {31'b0, flush_o}, 32'h1);
        chk("b2b_type_fl", excepttype_o, 32'h0);
        tick();
        chk("b2b_idle", {31'b0, flush_o}, 32'h0);
        chk("b2b_type2", excepttype_o, 32'hD);
        tick();
        chk("b2b_flush2", {31'b0, flush_o}, 32'h1);
        clear_inputs();
        tick();

        // Reset mid-FLUSH
        int_ext_i = 6'h3F;
        tick(); tick(); tick();
        chk("int_all", {26'b0, int_o}, 32'h3F);
        excepttype_raw_i = 32'h100; current_inst_addr_i = 32'h400; cp0_epc_i = 32'h500;
        tick();
        chk("rstfl_flush_pre", {31'b0, flush_o}, 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("rstfl_flush", {31'b0, flush_o}, 32'h0);
        chk("rstfl_int_o", {26'b0, int_o}, 32'h0);
        chk("rstfl_type", excepttype_o, 32'h0);
        chk("rstfl_pc", new_pc_o, 32'h0);
        clear_inputs();
        int_ext_i = '0;
        #1 rst = 1'b1;
        tick();
        chk("rstfl_idle", {31'b0, flush_o}, 32'h0);
        excepttype_raw_i = 32'h100; current_inst_addr_i = 32'h404;
        #1;
        chk("rstfl_after_type", excepttype_o, 32'h8);
        tick();
        chk("rstfl_after_flush", {31'b0, flush_o}, 32'h1);
        chk("rstfl_after_pc", new_pc_o, 32'h20);
        clear_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
